// File: rtl/prog_tick_timer.sv
// Prescaled base-tick generator with a one-shot/periodic down-count timer.
// Optional sticky interrupt output enabled by defining TIMER_STICKY_IRQ_EN.
module prog_tick_timer #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLKcount,
  input  logic             CLR,
  input  logic             EN,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
`ifdef TIMER_STICKY_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic             tick,
  output logic             flagEnable,
  output logic             busy,
  output logic [CNT_W-1:0] countVal
);

  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PC_W     = $clog2(PRESCALE);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (((CLK_HZ % TICK_HZ) != 0) || (PRESCALE < 2)) begin : g_cfg_err
    $error("prog_tick_timer: CLK_HZ/TICK_HZ must be an exact integer >= 2");
  end

  logic [0:0]       state_q,  state_d;
  logic [PC_W-1:0]  pc_q,     pc_d;
  logic             tick_q,   tick_d;
  logic             flag_q,   flag_d;
  logic             busy_q,   busy_d;
  logic             mode_q,   mode_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             stop_run;
  logic             start_ok;

  // stop outranks start, which outranks any expiry in the same cycle
  assign stop_run = stop && (state_q == ST_RUN);
  assign start_ok = start && (period != '0) && !stop_run;

  always_ff @(posedge CLKcount or posedge CLR) begin
    if (CLR) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      tick_q   <= 1'b0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tick_q   <= tick_d;
      flag_q   <= flag_d;
      busy_q   <= busy_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tick_d   = 1'b0;
    flag_d   = 1'b0;
    busy_d   = busy_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;

    // an accepted start re-phases the prescaler so the first tick is a full period away
    if (start_ok) begin
      pc_d = '0;
    end else if (EN) begin
      if (pc_q == PC_LAST) begin
        pc_d   = '0;
        tick_d = 1'b1;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end

    if (stop_run) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (start_ok) begin
      state_d  = ST_RUN;
      busy_d   = 1'b1;
      mode_d   = mode;
      cnt_d    = period;
      reload_d = period;
    end else if ((state_q == ST_RUN) && tick_q) begin
      if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        flag_d = 1'b1;
        if (mode_q) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
    end
  end

`ifdef TIMER_STICKY_IRQ_EN
  logic irq_q, irq_d;

  // a new expiry wins over a coincident clear
  always_comb begin
    irq_d = irq_q;
    if (flag_d) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge CLKcount or posedge CLR) begin
    if (CLR) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  assign tick       = tick_q;
  assign flagEnable = flag_q;
  assign busy       = busy_q;
  assign countVal   = cnt_q;

endmodule

// File: doc/prog_tick_timer.md
Name: prog_tick_timer

Overview:
Parametrised tick generator and programmable down-count timer, for use as the 50 MHz system timebase.
- A prescaler divides CLKcount into a one-cycle base tick every PRESCALE clocks, exactly, with no off-by-one.
- A timer counts a programmed number of base ticks and then pulses flagEnable.
- The timer runs in one-shot or periodic mode, with start/stop control and a readable remaining count.
- Replaces the fixed 1 s and 1 ms tick counters.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1000, base tick rate in Hz. PRESCALE = CLK_HZ/TICK_HZ. PRESCALE must be an exact integer and at least 2; elaboration fails otherwise.
- CNT_W, 16, width of the period and remaining-count fields.

Ports:
- CLKcount  in  1  system clock; all logic is on the rising edge.
- CLR  in  1  asynchronous active-high reset.
- EN  in  1  prescaler enable; 0 freezes the prescaler and the timer.
- start  in  1  one-cycle strobe; loads period and mode, then runs.
- stop  in  1  one-cycle strobe; aborts a running timer.
- mode  in  1  0 = one-shot, 1 = periodic; sampled only on start.
- period  in  CNT_W  number of base ticks per expiry; sampled only on start.
- tick  out  1  base tick; high for 1 cycle every PRESCALE cycles while EN=1.
- flagEnable  out  1  expiry pulse; high for 1 cycle.
- busy  out  1  high while in RUN.
- countVal  out  CNT_W  remaining ticks to expiry; 0 in IDLE.

Behaviour:
- All outputs are registered.
- Reset (CLR high) clears, asynchronously:
  - tick=0, flagEnable=0, busy=0, countVal=0;
  - prescaler count pc=0, reload=0, latched mode=0;
  - state=IDLE.
- Prescaler:
  - When EN=1 and pc==PRESCALE-1: pc<=0 and tick<=1.
  - Otherwise, when EN=1: pc<=pc+1 and tick<=0.
  - When EN=0: pc holds and tick<=0.
  - Any accepted start clears pc to 0, which phase-aligns ticks to the start.
- State IDLE:
  - start with period!=0: reload<=period, countVal<=period, mode latched, pc<=0, busy<=1, state<=RUN.
  - start with period==0: ignored; no state change, no pulse.
- State RUN, each edge at which registered tick==1:
  - countVal>1: countVal<=countVal-1.
  - countVal==1 and latched mode=1: flagEnable<=1, countVal<=reload, stay in RUN.
  - countVal==1 and latched mode=0: flagEnable<=1, countVal<=0, busy<=0, state<=IDLE.
- Latency:
  - With start sampled at edge t0, the first flagEnable is high in the cycle after edge t0 + period*PRESCALE + 1.
  - In periodic mode, later pulses follow every period*PRESCALE cycles.
- Priority within one cycle: stop, then start, then tick/expiry.
  - stop in RUN: state<=IDLE, busy<=0, countVal<=0; no flagEnable, even if expiry was due that cycle.
  - stop in IDLE: no effect.
  - start in RUN with period!=0: restart with the new period and mode; pc is cleared; no flagEnable for the abandoned count.
  - start in RUN with period==0: ignored; the current run continues.
- EN=0 in RUN: the timer pauses with countVal held and busy=1. It resumes where it left off when EN returns to 1.
- Widths and limits:
  - countVal never underflows, because the decrement only happens from a value of 2 or more.
  - The maximum period is 2^CNT_W-1.
  - The pc width is clog2(PRESCALE).
- CLR asserted mid-run aborts immediately to reset values. The first tick after release follows PRESCALE cycles of EN=1.

Optional Feature:
- Macro: TIMER_STICKY_IRQ_EN.
- When defined, the block adds two ports:
  - irq  out  1: set on any flagEnable, held until cleared; reset 0.
  - irq_clr  in  1: clears irq on the next edge.
  - irq_clr coinciding with a new expiry leaves irq=1, because set wins.
- When undefined, neither port exists and only the flagEnable pulse is provided.

Test Plan:
- Use CLK_HZ=1000, TICK_HZ=100 (PRESCALE=10), CNT_W=8 for all scenarios.
- Tick spacing: release CLR with EN=1 -> tick high for 1 cycle every 10 cycles, first one 10 cycles after release; tick stays 0 while EN=0.
- One-shot: start, period=3, mode=0 at t0 -> countVal steps 3,2,1; flagEnable high only in the cycle after edge t0+31; then busy=0, countVal=0, no further pulses.
- Periodic with restart: start, period=2, mode=1 -> flagEnable after edges t0+21, t0+41, t0+61; start with period=5 at t0+50 -> next pulse after edge t0+101.
- Stop and zero period: stop asserted in the same cycle as a due expiry -> no flagEnable, busy=0. start with period=0 in IDLE -> busy stays 0 and nothing happens.
- Pause and reset: EN=0 for 25 cycles mid-run -> expiry delayed by exactly 25 cycles. CLR pulse mid-run -> all outputs 0 immediately, asynchronously.
- TIMER_STICKY_IRQ_EN: irq rises with the first flagEnable and holds; irq_clr drops it the next cycle; irq_clr coinciding with an expiry -> irq remains 1.
